// File: rtl/flash_user_save.sv
`default_nettype none
// ============================================================================
// Module   : flash_user_save
// Purpose  : Write-side client of the flash arbiter. Accepts one 32-bit
//            configuration word at a time, requests the arbiter, issues a
//            4-byte write command and then streams the word MSB-first, one
//            byte per cycle. It releases the arbiter with a one-cycle pulse.
//            It uses the same word-to-flash address mapping as the
//            init-read client, so {addr[7:0], 4'h0} is the flash address.
// Ports    : clk_sys, rst_n              - clock, async active-low reset
//            mem_wr_en/addr/data         - word write request (user side)
//            mem_wr_ready                - idle, request can be accepted
//            mem_wr_done                 - word fully handed to arbiter
//            mem_wr_ovf                  - request dropped (block busy)
//            user_req/user_ack           - arbitration handshake
//            user_done                   - arbiter release pulse
//            user_en/user_cmd            - command strobe and command word
//            user_wr_data/_valid         - write byte stream
// Revision : 1.0 - initial release
// ============================================================================
module flash_user_save #(
    parameter int U_DLY = 1
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        mem_wr_en,
    input  logic [15:0] mem_wr_addr,
    input  logic [31:0] mem_wr_data,
    output logic        mem_wr_ready,
    output logic        mem_wr_done,
    output logic        mem_wr_ovf,
    output logic        user_req,
    input  logic        user_ack,
    output logic        user_done,
    output logic        user_en,
    output logic [31:0] user_cmd,
    output logic [7:0]  user_wr_data,
    output logic        user_wr_data_valid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARBIT = 3'd1,
        CMD   = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] cmd_q, cmd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  byte_sel;

    logic        user_req_q;
    logic        user_en_q;
    logic        user_valid_q;
    logic [7:0]  user_wr_data_q;
    logic        done_q;
    logic        ovf_q;

    // The delay parameter only exists for simulation models of the
    // original block; registers here update without delay. Upper address
    // bits are outside the 256-word save area.
    wire unused_inputs = (^mem_wr_addr[15:8]) ^ (U_DLY != 0);

    // Next-state and capture logic
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_wr_en) begin
                    state_d  = ARBIT;
                    shadow_d = mem_wr_data;
                    cmd_d    = {1'b0, 7'd0, 8'd4, 4'd0, mem_wr_addr[7:0], 4'd0};
                end
            end
            ARBIT: begin
                if (user_ack) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                state_d = DATA;
            end
            DATA: begin
                // 2-bit counter wraps 3 -> 0, leaving it cleared for the next word
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MSB-first byte selection from the shadow word
    always_comb begin
        byte_sel = shadow_q[31:24];
        case (cnt_q)
            2'd0: byte_sel = shadow_q[31:24];
            2'd1: byte_sel = shadow_q[23:16];
            2'd2: byte_sel = shadow_q[15:8];
            2'd3: byte_sel = shadow_q[7:0];
            default: byte_sel = shadow_q[31:24];
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            shadow_q       <= 32'd0;
            cmd_q          <= 32'd0;
            cnt_q          <= 2'd0;
            user_req_q     <= 1'b0;
            user_en_q      <= 1'b0;
            user_valid_q   <= 1'b0;
            user_wr_data_q <= 8'd0;
            done_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            // Strobes are registered decodes of the current state, so each
            // appears one cycle after the state it reflects.
            user_req_q   <= (state_q == ARBIT);
            user_en_q    <= (state_q == CMD);
            user_valid_q <= (state_q == DATA);
            done_q       <= (state_q == DONE);
            ovf_q        <= mem_wr_en && (state_q != IDLE);
            // Byte output holds its last value between transfers
            if (state_q == DATA) begin
                user_wr_data_q <= byte_sel;
            end
        end
    end

    assign mem_wr_ready       = (state_q == IDLE);
    assign mem_wr_done        = done_q;
    assign mem_wr_ovf         = ovf_q;
    assign user_req           = user_req_q;
    assign user_done          = done_q;
    assign user_en            = user_en_q;
    assign user_cmd           = cmd_q;
    assign user_wr_data       = user_wr_data_q;
    assign user_wr_data_valid = user_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_user_save.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_user_save
// Purpose  : Self-checking bench for flash_user_save. Table vectors and
//            random transactions are checked cycle by cycle against a model
//            of the handshake expressed as cycle offsets from the request
//            and the acknowledge, with bytes derived arithmetically from the
//            stored word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_user_save;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        mem_wr_done;
    logic        mem_wr_ovf;
    logic        user_req;
    logic        user_ack;
    logic        user_done;
    logic        user_en;
    logic [31:0] user_cmd;
    logic [7:0]  user_wr_data;
    logic        user_wr_data_valid;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;

    flash_user_save #(.U_DLY(1)) dut (
        .clk_sys            (clk_sys),
        .rst_n              (rst_n),
        .mem_wr_en          (mem_wr_en),
        .mem_wr_addr        (mem_wr_addr),
        .mem_wr_data        (mem_wr_data),
        .mem_wr_ready       (mem_wr_ready),
        .mem_wr_done        (mem_wr_done),
        .mem_wr_ovf         (mem_wr_ovf),
        .user_req           (user_req),
        .user_ack           (user_ack),
        .user_done          (user_done),
        .user_en            (user_en),
        .user_cmd           (user_cmd),
        .user_wr_data       (user_wr_data),
        .user_wr_data_valid (user_wr_data_valid)
    );

    always #5 clk_sys = ~clk_sys;

    // Count command strobes to detect missing or extra transactions
    always @(negedge clk_sys) begin
        if (user_en === 1'b1) en_cnt <= en_cnt + 1;
    end

    // One transaction: ack_at is the cycle (counted from the request cycle,
    // >= 1) where ack is first high; hold is how many cycles ack stays high;
    // ovf_k is the cycle of an extra request while busy (-1 for none).
    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          ack_at;
        int          hold;
        int          ovf_k;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [31:0] exp_byte(input logic [31:0] d, input int i);
        return (d >> (24 - 8 * i)) & 32'hFF;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ready"}, {31'd0, mem_wr_ready}, 32'd1);
        chk({tag, " req"},   {31'd0, user_req}, 32'd0);
        chk({tag, " en"},    {31'd0, user_en}, 32'd0);
        chk({tag, " valid"}, {31'd0, user_wr_data_valid}, 32'd0);
        chk({tag, " data"},  {24'd0, user_wr_data}, 32'd0);
        chk({tag, " udone"}, {31'd0, user_done}, 32'd0);
        chk({tag, " wdone"}, {31'd0, mem_wr_done}, 32'd0);
        chk({tag, " ovf"},   {31'd0, mem_wr_ovf}, 32'd0);
        chk({tag, " cmd"},   user_cmd, 32'd0);
    endtask

    // Entered in a cycle where the block is idle; returns in the cycle where
    // the done pulse is visible, so calls may run back-to-back.
    task automatic do_write(input vec_t v);
        int          n;
        int          en_before;
        logic [31:0] exp_cmd;
        n         = v.ack_at + 7;
        en_before = en_cnt;
        exp_cmd   = 32'h0004_0000 | ({24'd0, v.addr[7:0]} << 4);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) tick();
            mem_wr_en = (k == 0) || (k == v.ovf_k);
            if (k == 0) begin
                mem_wr_addr = v.addr;
                mem_wr_data = v.data;
            end else begin
                mem_wr_addr = 16'($urandom);
                mem_wr_data = $urandom;
            end
            user_ack = (k >= v.ack_at) && (k < v.ack_at + v.hold);
            if (k > 0) begin
                chk("ready", {31'd0, mem_wr_ready}, {31'd0, k == n});
                chk("req",   {31'd0, user_req}, {31'd0, (k >= 2) && (k <= v.ack_at + 1)});
                chk("en",    {31'd0, user_en}, {31'd0, k == v.ack_at + 2});
                chk("valid", {31'd0, user_wr_data_valid},
                    {31'd0, (k >= v.ack_at + 3) && (k <= v.ack_at + 6)});
                if ((k >= v.ack_at + 3) && (k <= v.ack_at + 6))
                    chk("byte", {24'd0, user_wr_data}, exp_byte(v.data, k - v.ack_at - 3));
                chk("udone", {31'd0, user_done}, {31'd0, k == n});
                chk("wdone", {31'd0, mem_wr_done}, {31'd0, k == n});
                chk("ovf",   {31'd0, mem_wr_ovf}, {31'd0, (v.ovf_k > 0) && (k == v.ovf_k + 1)});
                if (k == v.ack_at + 2 || k == n)
                    chk("cmd", user_cmd, exp_cmd);
            end
        end
        mem_wr_en = 1'b0;
        user_ack  = 1'b0;
        chk("held byte", {24'd0, user_wr_data}, {24'd0, v.data[7:0]});
        chk("en pulses", en_cnt - en_before, 32'd1);
    endtask

    initial begin
        vec_t v;
        int   en_before;

        vecs[0] = '{addr: 16'h0012, data: 32'hA1B2C3D4, ack_at: 2,  hold: 3, ovf_k: -1};
        vecs[1] = '{addr: 16'h0020, data: 32'h0F1E2D3C, ack_at: 51, hold: 1, ovf_k: -1};
        vecs[2] = '{addr: 16'h0034, data: 32'hDEADBEEF, ack_at: 1,  hold: 1, ovf_k: 5};
        vecs[3] = '{addr: 16'hAB01, data: 32'h11223344, ack_at: 1,  hold: 1, ovf_k: -1};
        vecs[4] = '{addr: 16'hABFF, data: 32'h55667788, ack_at: 1,  hold: 1, ovf_k: -1};

        rst_n       = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = 16'd0;
        mem_wr_data = 32'd0;
        user_ack    = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Stray acknowledges while idle must not start anything
        en_before = en_cnt;
        for (int i = 0; i < 6; i++) begin
            user_ack = (i < 4);
            tick();
            chk("stray req",   {31'd0, user_req}, 32'd0);
            chk("stray ready", {31'd0, mem_wr_ready}, 32'd1);
        end
        chk("stray en pulses", en_cnt - en_before, 32'd0);

        for (int i = 0; i < 5; i++) do_write(vecs[i]);

        // Reset while the second byte is on the bus
        tick();
        mem_wr_en = 1'b1; mem_wr_addr = 16'h0056; mem_wr_data = 32'hCAFEF00D;
        tick();
        mem_wr_en = 1'b0; user_ack = 1'b1;
        tick();
        user_ack = 1'b0;
        tick();
        tick();
        tick();
        chk("pre-reset valid", {31'd0, user_wr_data_valid}, 32'd1);
        chk("pre-reset byte",  {24'd0, user_wr_data}, 32'hFE);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        v = '{addr: 16'h0078, data: 32'h0BADCAFE, ack_at: 1, hold: 1, ovf_k: -1};
        do_write(v);

        // Random transactions
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            v.addr   = 16'($urandom);
            v.data   = $urandom;
            v.ack_at = int'($urandom_range(1, 6));
            v.hold   = int'($urandom_range(1, 3));
            v.ovf_k  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, v.ack_at + 6)) : -1;
            do_write(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_user_save.md
# flash_user_save

Write-side client of the flash arbiter: takes single 32-bit configuration words from the user/config register side and commits each to flash. Requests the arbiter, issues a 4-byte write command, streams the word MSB-first as bytes, then releases the arbiter. Mirror of the init-read client; uses the same word-to-flash address mapping, so saved words read back at the same `mem_rd_addr`.

## Interface
- `U_DLY`, default 1: simulation delay on registered assignments.

- `clk_sys`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_wr_en`  in  1  one-cycle write request; accepted only while `mem_wr_ready`=1.
- `mem_wr_addr`  in  16  word address; only [7:0] used.
- `mem_wr_data`  in  32  word to store.
- `mem_wr_ready`  out  1  block idle; decode of state==IDLE.
- `mem_wr_done`  out  1  one-cycle pulse when the word has been fully handed to the arbiter.
- `mem_wr_ovf`  out  1  one-cycle pulse: `mem_wr_en` seen while not ready (request dropped).
- `user_req`  out  1  arbitration request.
- `user_ack`  in  1  grant from arbiter.
- `user_done`  out  1  one-cycle release pulse.
- `user_en`  out  1  one-cycle command strobe.
- `user_cmd`  out  32  [31]=0 write, [30:24]=0, [23:16]=length, [15:0]=flash address.
- `user_wr_data`  out  8  write byte.
- `user_wr_data_valid`  out  1  byte strobe.

## Operation
- States: IDLE, ARBIT, CMD, DATA, DONE.
  - IDLE: `mem_wr_en`=1 -> ARBIT; latch `mem_wr_data` into a 32-bit shadow and build `user_cmd` = {1'b0, 7'd0, 8'd4, 4'd0, mem_wr_addr[7:0], 4'd0}.
  - ARBIT: `user_ack`=1 -> CMD, else stay (no timeout).
  - CMD -> DATA unconditionally.
  - DATA: 2-bit byte counter 0..3; counter==3 -> DONE, counter clears to 0.
  - DONE -> IDLE.
- `user_ack` outside ARBIT ignored. `mem_wr_en` outside IDLE ignored except for `mem_wr_ovf`; shadow word and `user_cmd` never change outside IDLE capture.
- Registered outputs: `user_req` <= (state==ARBIT); `user_en` <= (state==CMD); `user_wr_data_valid` <= (state==DATA); `user_wr_data` <= shadow byte (counter 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]); `user_done` and `mem_wr_done` <= (state==DONE); `mem_wr_ovf` <= `mem_wr_en` & (state!=IDLE).
- `user_wr_data` holds last byte when valid low. No backpressure on bytes; arbiter accepts one per cycle after `user_en`.
- Reset values: state IDLE, all outputs 0 except `mem_wr_ready`=1; `user_cmd`=0, shadow 0, counter 0. Reset mid-transfer aborts immediately with these values; no partial-word resume.

## Timing
- T0: `mem_wr_en`=1 in IDLE. T1: state ARBIT, `mem_wr_ready`=0, `user_cmd` valid. T2: `user_req`=1.
- `user_ack` sampled high at Ta (Ta>=T1): `user_req` stays high through Ta+1, low from Ta+2.
- Ta+2: `user_en`=1, `user_cmd` stable.
- Ta+3..Ta+6: `user_wr_data_valid`=1, bytes D[31:24], D[23:16], D[15:8], D[7:0].
- Ta+7: `user_done`=1, `mem_wr_done`=1, `mem_wr_ready`=1 (state IDLE).
- Back-to-back: new `mem_wr_en` accepted at Ta+7; minimum request period 8 cycles with ack at T1.
- `mem_wr_ovf` one cycle after the offending `mem_wr_en`.

## Test plan
- Reset: `rst_n` low -> all outputs 0, `mem_wr_ready`=1, `user_cmd`=0.
- Single write addr 0x0012, data 0xA1B2C3D4, ack held 3 cycles after `user_req` rises -> `user_cmd`=0x00040120 at `user_en`; bytes A1,B2,C3,D4 on four consecutive cycles; `user_done`/`mem_wr_done` pulse one cycle after last byte.
- Ack delayed 50 cycles -> `user_req` high continuously, no `user_en`/bytes until 2 cycles after ack; stray ack pulses in IDLE cause no activity.
- `mem_wr_en` during DATA with other addr/data -> `mem_wr_ovf` pulse, current bytes and `user_cmd` unchanged, no second transaction.
- Two writes back-to-back (0x01/0x11223344 then 0xFF/0x55667788, upper addr bits 0xAB set) -> second `user_cmd`=0x00040FF0, bytes 55,66,77,88, two `mem_wr_done` pulses.
- Reset asserted on second byte -> outputs return to reset values immediately; next write after release completes normally with counter starting at byte [31:24].
